// File: rtl/weight_buf_sched_if.sv
// Bundles the command, DDR beat and weight-buffer signals of the weight
// buffer scheduler. The slave modport is the scheduler itself; the master
// modport is whatever drives it (layer controller, DDR engine, buffer).
interface weight_buf_sched_if #(
  parameter int ADDR_LEN     = 16,
  parameter int DDR_DATA_LEN = 256,
  parameter int BUFFER_NUM   = 32,
  parameter int LEN_W        = 16
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_op;
  logic [ADDR_LEN-1:0]     cmd_base;
  logic [LEN_W-1:0]        cmd_len;

  logic                    ddr_valid;
  logic                    ddr_ready;
  logic [DDR_DATA_LEN-1:0] ddr_data;

  logic [DDR_DATA_LEN-1:0] data_wr;
  logic [ADDR_LEN-1:0]     wr_addr;
  logic [BUFFER_NUM-1:0]   wr_en;
  logic                    rd_conf;
  logic [ADDR_LEN-1:0]     st_rd_addr;
  logic                    buf_idle;
  logic                    ker_en;

  logic                    pe_ready;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len,
    output ddr_valid, ddr_data,
    output buf_idle, ker_en, pe_ready,
    input  cmd_ready, ddr_ready,
    input  data_wr, wr_addr, wr_en, rd_conf, st_rd_addr,
    input  busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len,
    input  ddr_valid, ddr_data,
    input  buf_idle, ker_en, pe_ready,
    output cmd_ready, ddr_ready,
    output data_wr, wr_addr, wr_en, rd_conf, st_rd_addr,
    output busy, done, err
  );

endinterface

// File: rtl/weight_buf_sched.sv
// Weight buffer scheduler: runs one command at a time. LOAD streams DDR
// beats into consecutive bank groups and rows; READ issues kernel-set read
// starts and waits for the buffer to raise ker_en for each set.
// Optional feature: define WEIGHT_BUF_SCHED_TIMEOUT_EN to add a 5-bit
// watchdog on RD_WAIT that sets a sticky err and aborts the command.
module weight_buf_sched #(
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int DDR_DATA_LEN = 256,
  parameter int BUFFER_NUM   = 32,
  parameter int LEN_W        = 16,
  parameter int RD_STRIDE    = 9
) (
  input logic               clk,
  input logic               rst_n,
  weight_buf_sched_if.slave bus
);

  localparam int BPB    = DDR_DATA_LEN / DATA_LEN;
  localparam int GROUPS = BUFFER_NUM / BPB;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GRP_W-1:0]      GRP_LAST  = GRP_W'(GROUPS - 1);
  localparam logic [BUFFER_NUM-1:0] BANK_MASK = BUFFER_NUM'({BPB{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_LEN-1:0] base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    row;
  logic [GRP_W-1:0]    grp;
  logic [LEN_W-1:0]    set_cnt;
  logic [ADDR_LEN-1:0] rd_ptr;
  logic                ker_en_d;
  logic                ker_rise;

`ifdef WEIGHT_BUF_SCHED_TIMEOUT_EN
  logic [4:0]          wd;
  logic                err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.ddr_ready = (state == S_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign ker_rise      = bus.ker_en && !ker_en_d;

  // Delayed copy of ker_en so only a fresh rise counts as set completion.
  always_ff @(posedge clk) begin
    if (!rst_n) ker_en_d <= 1'b0;
    else        ker_en_d <= bus.ker_en;
  end

  // Main sequencer: command capture, beat writes, read issue/wait, done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      row            <= '0;
      grp            <= '0;
      set_cnt        <= '0;
      rd_ptr         <= '0;
      bus.data_wr    <= '0;
      bus.wr_addr    <= '0;
      bus.wr_en      <= '0;
      bus.rd_conf    <= 1'b0;
      bus.st_rd_addr <= '0;
      bus.done       <= 1'b0;
`ifdef WEIGHT_BUF_SCHED_TIMEOUT_EN
      wd             <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      bus.wr_en   <= '0;
      bus.rd_conf <= 1'b0;
      bus.done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            base_q  <= bus.cmd_base;
            len_q   <= bus.cmd_len;
            rd_ptr  <= bus.cmd_base;
            row     <= '0;
            grp     <= '0;
            set_cnt <= '0;
            if (bus.cmd_len == '0) state <= S_DONE;
            else if (bus.cmd_op)   state <= S_RD_ISSUE;
            else                   state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.ddr_valid) begin
            bus.data_wr <= bus.ddr_data;
            bus.wr_addr <= base_q + ADDR_LEN'(row);
            bus.wr_en   <= BANK_MASK << (BPB * int'(grp));
            if (grp == GRP_LAST) begin
              grp <= '0;
              row <= row + LEN_W'(1);
              if (row == len_q - LEN_W'(1)) state <= S_DONE;
            end else begin
              grp <= grp + GRP_W'(1);
            end
          end
        end
        S_RD_ISSUE: begin
          if (bus.buf_idle && bus.pe_ready) begin
            bus.rd_conf    <= 1'b1;
            bus.st_rd_addr <= rd_ptr;
            rd_ptr         <= rd_ptr + ADDR_LEN'(RD_STRIDE);
            state          <= S_RD_WAIT;
`ifdef WEIGHT_BUF_SCHED_TIMEOUT_EN
            wd             <= '0;
`endif
          end
        end
        S_RD_WAIT: begin
          if (ker_rise) begin
            set_cnt <= set_cnt + LEN_W'(1);
            if (set_cnt + LEN_W'(1) == len_q) state <= S_DONE;
            else                              state <= S_RD_ISSUE;
          end
`ifdef WEIGHT_BUF_SCHED_TIMEOUT_EN
          else if (wd == 5'd30) begin
            wd    <= 5'd31;
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            wd <= wd + 5'd1;
          end
`endif
        end
        S_DONE: begin
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
